// File: rtl/video_timing_gen.sv
// Raster timing generator: h/v counters with sync, display-enable and position decode,
// frame counter, and a pix_ce-gated delay line for the sync/enable outputs.
module video_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int H_POL    = 0,
    parameter int V_POL    = 0,
    parameter int PIPE     = 2,
    parameter int XW       = 10,
    parameter int YW       = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pix_ce,
    input  logic          en,
    output logic          hsync_o,
    output logic          vsync_o,
    output logic          de_o,
    output logic          vblank_o,
    output logic [XW-1:0] posx_o,
    output logic [YW-1:0] posy_o,
    output logic          line_start_o,
    output logic          frame_start_o,
    output logic [7:0]    frame_cnt_o,
    output logic          hsync_d_o,
    output logic          vsync_d_o,
    output logic          de_d_o
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_TOTAL - 1 >= 2 ** XW) begin : g_xw_chk
        $error("XW too narrow for H_TOTAL-1");
    end
    if (V_TOTAL - 1 >= 2 ** YW) begin : g_yw_chk
        $error("YW too narrow for V_TOTAL-1");
    end
    if (H_SYNC < 1 || V_SYNC < 1) begin : g_sync_chk
        $error("sync widths must be at least 1");
    end
    if (PIPE < 0 || PIPE > 8) begin : g_pipe_chk
        $error("PIPE must be in 0..8");
    end

    localparam logic [XW-1:0] H_LAST   = XW'(H_TOTAL - 1);
    localparam logic [YW-1:0] V_LAST   = YW'(V_TOTAL - 1);
    localparam logic [XW-1:0] H_ACT_C  = XW'(H_ACTIVE);
    localparam logic [YW-1:0] V_ACT_C  = YW'(V_ACTIVE);
    localparam logic [XW-1:0] HS_FIRST = XW'(H_ACTIVE + H_FP);
    localparam logic [XW-1:0] HS_LAST  = XW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [YW-1:0] VS_FIRST = YW'(V_ACTIVE + V_FP);
    localparam logic [YW-1:0] VS_LAST  = YW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic          HS_ON    = 1'(H_POL);
    localparam logic          VS_ON    = 1'(V_POL);

    logic [XW-1:0] r_h;
    logic [YW-1:0] r_v;
    logic [XW-1:0] w_h_nxt;
    logic [YW-1:0] w_v_nxt;
    logic          w_de_nxt;
    logic          w_hs_nxt;
    logic          w_vs_nxt;
    logic          w_idle;

    assign w_idle = rst || !en;

    always_comb begin
        w_h_nxt = r_h + XW'(1);
        w_v_nxt = r_v;
        if (r_h == H_LAST) begin
            w_h_nxt = '0;
            w_v_nxt = (r_v == V_LAST) ? '0 : r_v + YW'(1);
        end
        w_de_nxt = (w_h_nxt < H_ACT_C) && (w_v_nxt < V_ACT_C);
        w_hs_nxt = (w_h_nxt >= HS_FIRST && w_h_nxt <= HS_LAST) ? HS_ON : ~HS_ON;
        w_vs_nxt = (w_v_nxt >= VS_FIRST && w_v_nxt <= VS_LAST) ? VS_ON : ~VS_ON;
    end

    // Outputs decode the counter value being loaded, so they share the counters' latency.
    always_ff @(posedge clk) begin
        if (w_idle) begin
            r_h           <= H_LAST;
            r_v           <= V_LAST;
            hsync_o       <= ~HS_ON;
            vsync_o       <= ~VS_ON;
            de_o          <= 1'b0;
            vblank_o      <= 1'b1;
            posx_o        <= '0;
            posy_o        <= '0;
            line_start_o  <= 1'b0;
            frame_start_o <= 1'b0;
            if (rst) begin
                frame_cnt_o <= '0;
            end
        end else if (pix_ce) begin
            r_h           <= w_h_nxt;
            r_v           <= w_v_nxt;
            hsync_o       <= w_hs_nxt;
            vsync_o       <= w_vs_nxt;
            de_o          <= w_de_nxt;
            vblank_o      <= (w_v_nxt >= V_ACT_C);
            posx_o        <= w_de_nxt ? w_h_nxt : '0;
            posy_o        <= (w_v_nxt < V_ACT_C) ? w_v_nxt : '0;
            line_start_o  <= (w_h_nxt == '0);
            frame_start_o <= (w_h_nxt == '0) && (w_v_nxt == '0);
            if (w_h_nxt == '0 && w_v_nxt == '0) begin
                frame_cnt_o <= frame_cnt_o + 8'd1;
            end
        end else begin
            line_start_o  <= 1'b0;
            frame_start_o <= 1'b0;
        end
    end

    if (PIPE > 0) begin : g_pipe
        logic [PIPE-1:0] r_hs_sr;
        logic [PIPE-1:0] r_vs_sr;
        logic [PIPE-1:0] r_de_sr;

        // Each stage captures the output value from before this pix_ce step.
        always_ff @(posedge clk) begin
            if (w_idle) begin
                r_hs_sr <= {PIPE{~HS_ON}};
                r_vs_sr <= {PIPE{~VS_ON}};
                r_de_sr <= '0;
            end else if (pix_ce) begin
                r_hs_sr[0] <= hsync_o;
                r_vs_sr[0] <= vsync_o;
                r_de_sr[0] <= de_o;
                for (int i = 1; i < PIPE; i++) begin
                    r_hs_sr[i] <= r_hs_sr[i-1];
                    r_vs_sr[i] <= r_vs_sr[i-1];
                    r_de_sr[i] <= r_de_sr[i-1];
                end
            end
        end

        assign hsync_d_o = r_hs_sr[PIPE-1];
        assign vsync_d_o = r_vs_sr[PIPE-1];
        assign de_d_o    = r_de_sr[PIPE-1];
    end else begin : g_nopipe
        assign hsync_d_o = hsync_o;
        assign vsync_d_o = vsync_o;
        assign de_d_o    = de_o;
    end

endmodule
